// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// -----------------------------------------------------------------------------
// Shares the single burst memory port (bmem) between the data cache, the
// instruction cache demand path and the instruction-cache next-line
// prefetcher. Only one line transaction is in flight at a time. Line writes
// are cut into BEAT_SIZE beats, read beats are packed back into a line.
//
// Optional feature macro: ARB_PREFETCH_EN
//   defined   -> prefetch requester, one-entry prefetch line buffer and
//                active_prefetch are built
//   undefined -> prefetch inputs ignored, prefetch outputs tied to 0
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   d_addr/d_read/d_write/d_wdata -> d_rdata/d_resp   dcache line port
//   i_addr/i_read               -> i_rdata/i_resp      icache demand port
//   prefetch/prefetch_addr      -> prefetch_rdata/prefetch_raddr/
//                                  prefetch_rvalid, active_prefetch
//   flush_prefetch              consumer releases the buffered line
//   bmem_addr/bmem_read/bmem_write/bmem_wdata          memory request side
//   bmem_ready/bmem_raddr/bmem_rdata/bmem_rvalid       memory response side
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int LINE_SIZE = 256,
    parameter int BEAT_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          d_addr,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [LINE_SIZE-1:0] d_wdata,
    output logic [LINE_SIZE-1:0] d_rdata,
    output logic                 d_resp,
    input  logic [31:0]          i_addr,
    input  logic                 i_read,
    output logic [LINE_SIZE-1:0] i_rdata,
    output logic                 i_resp,
    input  logic                 prefetch,
    input  logic [31:0]          prefetch_addr,
    output logic [LINE_SIZE-1:0] prefetch_rdata,
    output logic [31:0]          prefetch_raddr,
    output logic                 prefetch_rvalid,
    input  logic                 flush_prefetch,
    output logic                 active_prefetch,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_SIZE-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_SIZE-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);

    localparam int         BEATS     = LINE_SIZE / BEAT_SIZE;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, RESP} state_t;
    typedef enum logic [1:0] {OWN_D, OWN_I, OWN_P} owner_t;

    state_t               r_state;
    state_t               w_nextState;
    owner_t               r_owner;
    logic [31:0]          r_addr;
    logic [1:0]           r_beat;
    logic [LINE_SIZE-1:0] r_line;

    logic [31:0] w_dAddr;
    logic [31:0] w_iAddr;
    logic        w_grantD;
    logic        w_grantI;
    logic        w_grantP;
    logic        w_unused;

    assign w_dAddr  = {d_addr[31:5], 5'b0};
    assign w_iAddr  = {i_addr[31:5], 5'b0};
    assign w_grantD = d_read | d_write;
    assign w_grantI = ~w_grantD & i_read;

`ifdef ARB_PREFETCH_EN
    logic                 r_pfValid;
    logic                 r_activePf;
    logic [31:0]          r_pfAddr;
    logic [LINE_SIZE-1:0] r_pfData;
    logic [31:0]          w_pfAddr;
    logic                 w_pfEligible;

    // A prefetch for the very line the icache is demanding this cycle is
    // pointless, and a full buffer or outstanding prefetch blocks new ones.
    assign w_pfAddr     = {prefetch_addr[31:5], 5'b0};
    assign w_pfEligible = prefetch & ~r_pfValid & ~r_activePf
                          & ~(i_read && (w_pfAddr == w_iAddr));
    assign w_grantP     = ~w_grantD & ~i_read & w_pfEligible;
    assign w_unused     = ^{d_addr[4:0], i_addr[4:0], prefetch_addr[4:0], bmem_raddr};
`else
    assign w_grantP = 1'b0;
    assign w_unused = ^{d_addr[4:0], i_addr[4:0], prefetch, prefetch_addr,
                        flush_prefetch, bmem_raddr};
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Writes only come from the dcache, so the IDLE
    // decision between read and write paths looks at d_write directly.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (d_write) begin
                    w_nextState = WR_DATA;
                end else if (d_read || w_grantI || w_grantP) begin
                    w_nextState = RD_REQ;
                end
            end
            RD_REQ:  if (bmem_ready) w_nextState = RD_DATA;
            RD_DATA: if (bmem_rvalid && r_beat == LAST_BEAT) w_nextState = RESP;
            WR_DATA: if (bmem_ready && r_beat == LAST_BEAT) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Transaction datapath: grant latch, beat counter and line assembly.
    // Beats arriving outside RD_DATA fall through the default arm.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner <= OWN_D;
            r_addr  <= '0;
            r_beat  <= '0;
            r_line  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantD) begin
                        r_owner <= OWN_D;
                        r_addr  <= w_dAddr;
                        r_beat  <= '0;
                    end else if (w_grantI) begin
                        r_owner <= OWN_I;
                        r_addr  <= w_iAddr;
                        r_beat  <= '0;
                    end else if (w_grantP) begin
                        r_owner <= OWN_P;
`ifdef ARB_PREFETCH_EN
                        r_addr  <= w_pfAddr;
`endif
                        r_beat  <= '0;
                    end
                end
                RD_DATA: begin
                    if (bmem_rvalid) begin
                        r_line[int'(r_beat)*BEAT_SIZE +: BEAT_SIZE] <= bmem_rdata;
                        r_beat <= r_beat + 2'd1;
                    end
                end
                WR_DATA: begin
                    if (bmem_ready) begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode. Everything is zero outside the state that owns it, so
    // resp and rdata are single-cycle and data buses idle at 0.
    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        d_resp     = 1'b0;
        d_rdata    = '0;
        i_resp     = 1'b0;
        i_rdata    = '0;
        case (r_state)
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = r_addr;
            end
            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_addr  = r_addr;
                bmem_wdata = d_wdata[int'(r_beat)*BEAT_SIZE +: BEAT_SIZE];
            end
            RESP: begin
                if (r_owner == OWN_D) begin
                    d_resp  = 1'b1;
                    d_rdata = r_line;
                end else if (r_owner == OWN_I) begin
                    i_resp  = 1'b1;
                    i_rdata = r_line;
                end
            end
            default: ;
        endcase
    end

`ifdef ARB_PREFETCH_EN
    // Prefetch buffer. Loading happens only when the buffer is empty, so a
    // flush can only ever hit an existing valid entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pfValid  <= 1'b0;
            r_activePf <= 1'b0;
            r_pfAddr   <= '0;
            r_pfData   <= '0;
        end else begin
            if (r_state == IDLE && w_grantP) begin
                r_activePf <= 1'b1;
            end
            if (r_pfValid && flush_prefetch) begin
                r_pfValid <= 1'b0;
            end
            if (r_state == RESP && r_owner == OWN_P) begin
                r_pfValid  <= 1'b1;
                r_pfAddr   <= r_addr;
                r_pfData   <= r_line;
                r_activePf <= 1'b0;
            end
        end
    end

    assign prefetch_rvalid = r_pfValid;
    assign prefetch_raddr  = r_pfAddr;
    assign prefetch_rdata  = r_pfData;
    assign active_prefetch = r_activePf;
`else
    assign prefetch_rvalid = 1'b0;
    assign prefetch_raddr  = '0;
    assign prefetch_rdata  = '0;
    assign active_prefetch = 1'b0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// -----------------------------------------------------------------------------
// Directed bench for cache_mem_arbiter. Stimulus pushes expected responses,
// expected read addresses and expected write beats into queues; a monitor
// pops and compares them whenever the DUT presents a response or a bmem
// handshake. A small memory model returns queued lines as four beats.
// The prefetch scenario is built when ARB_PREFETCH_EN is defined; otherwise
// the bench checks that prefetch requests are ignored.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    logic         clk;
    logic         rst;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         prefetch;
    logic [31:0]  prefetch_addr;
    logic [255:0] prefetch_rdata;
    logic [31:0]  prefetch_raddr;
    logic         prefetch_rvalid;
    logic         flush_prefetch;
    logic         active_prefetch;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    typedef struct {
        bit           isD;
        bit           chkData;
        logic [255:0] data;
        int           cycle;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wbeat_t;

    resp_t        expResp[$];
    logic [31:0]  expRdAddr[$];
    wbeat_t       expWr[$];
    logic [255:0] memLineQ[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strayCount = 0;
    int readyPat [6] = '{1, 0, 1, 1, 0, 1};

    cache_mem_arbiter #(.LINE_SIZE(256), .BEAT_SIZE(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .d_addr          (d_addr),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_wdata         (d_wdata),
        .d_rdata         (d_rdata),
        .d_resp          (d_resp),
        .i_addr          (i_addr),
        .i_read          (i_read),
        .i_rdata         (i_rdata),
        .i_resp          (i_resp),
        .prefetch        (prefetch),
        .prefetch_addr   (prefetch_addr),
        .prefetch_rdata  (prefetch_rdata),
        .prefetch_raddr  (prefetch_raddr),
        .prefetch_rvalid (prefetch_rvalid),
        .flush_prefetch  (flush_prefetch),
        .active_prefetch (active_prefetch),
        .bmem_addr       (bmem_addr),
        .bmem_read       (bmem_read),
        .bmem_write      (bmem_write),
        .bmem_wdata      (bmem_wdata),
        .bmem_ready      (bmem_ready),
        .bmem_raddr      (bmem_raddr),
        .bmem_rdata      (bmem_rdata),
        .bmem_rvalid     (bmem_rvalid)
    );

    // 10-unit clock; cyc numbers the cycle that starts at each rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] mkLine(input logic [63:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit dRd, input bit dWr, input bit iRd,
                                 input logic [31:0] dA, input logic [31:0] iA,
                                 input logic [255:0] wd);
        d_read  = dRd;
        d_write = dWr;
        i_read  = iRd;
        d_addr  = dA;
        i_addr  = iA;
        d_wdata = wd;
    endtask

    // Waits (bounded) for the selected resp pulse; leaves the caller at
    // negedge+1 of the resp cycle so the request can be dropped there.
    task automatic waitResp(input bit isD, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = isD ? d_resp : i_resp;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_timeout: resp not seen in 40 cycles, expected a resp", name);
        end
    endtask

    // Memory model: one accepted read handshake starts four back-to-back
    // beats of the next queued line. strayCount injects junk beats.
    initial begin : memModel
        int           beatsLeft;
        int           beatIdx;
        logic [255:0] curLine;
        beatsLeft   = 0;
        beatIdx     = 0;
        curLine     = '0;
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        bmem_raddr  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (beatsLeft > 0) begin
                bmem_rvalid = 1'b1;
                bmem_rdata  = curLine[beatIdx*64 +: 64];
                beatIdx++;
                beatsLeft--;
            end else if (strayCount > 0) begin
                bmem_rvalid = 1'b1;
                bmem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
                strayCount--;
            end else begin
                bmem_rvalid = 1'b0;
                bmem_rdata  = '0;
            end
            if (rst && bmem_read && bmem_ready) begin
                curLine    = (memLineQ.size() > 0) ? memLineQ.pop_front() : '0;
                bmem_raddr = bmem_addr;
                beatsLeft  = 4;
                beatIdx    = 0;
            end
        end
    end

    // Scoreboard monitor: compares responses, read request addresses and
    // accepted write beats against what the stimulus queued.
    initial begin : monitor
        resp_t       e;
        wbeat_t      w;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (d_resp || i_resp) begin
                    if (expResp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_resp: d_resp=%0b i_resp=%0b, expected none", d_resp, i_resp);
                    end else begin
                        e = expResp.pop_front();
                        checkOutput("resp_source", {d_resp, i_resp}, e.isD ? 2'b10 : 2'b01);
                        if (e.chkData) checkOutput("resp_rdata", e.isD ? d_rdata : i_rdata, e.data);
                        checkOutput("resp_cycle", cyc, e.cycle);
                    end
                end
                if (bmem_read && bmem_ready) begin
                    if (expRdAddr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_read: addr %h, expected no read", bmem_addr);
                    end else begin
                        a = expRdAddr.pop_front();
                        checkOutput("bmem_read_addr", bmem_addr, a);
                    end
                end
                if (bmem_write && bmem_ready) begin
                    if (expWr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write: data %h, expected no write", bmem_wdata);
                    end else begin
                        w = expWr.pop_front();
                        checkOutput("bmem_write_beat", {bmem_addr, bmem_wdata}, {w.addr, w.data});
                    end
                end
            end
        end
    end

    // Directed scenarios.
    initial begin : stimulus
        int           n;
        logic [255:0] line;
        logic [255:0] line2;
        logic [255:0] wd;

        rst            = 1'b0;
        prefetch       = 1'b0;
        prefetch_addr  = '0;
        flush_prefetch = 1'b0;
        bmem_ready     = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, '0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_d_resp", d_resp, 1'b0);
        checkOutput("rst_i_resp", i_resp, 1'b0);
        checkOutput("rst_bmem_read", bmem_read, 1'b0);
        checkOutput("rst_bmem_write", bmem_write, 1'b0);
        checkOutput("rst_bmem_addr", bmem_addr, 32'h0);
        checkOutput("rst_pf_rvalid", prefetch_rvalid, 1'b0);
        checkOutput("rst_active_pf", active_prefetch, 1'b0);
        checkOutput("rst_pf_rdata", prefetch_rdata, 256'h0);
        @(negedge clk);
        rst = 1'b1;

        // icache demand read, unaligned address
        @(negedge clk);
        n    = cyc;
        line = mkLine(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                      64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        memLineQ.push_back(line);
        expRdAddr.push_back(32'h0000_1000);
        expResp.push_back('{1'b0, 1'b1, line, n + 6});
        applyStimulus(0, 0, 1, 32'h0, 32'h0000_1004, '0);
        waitResp(0, "iread1");
        i_read = 1'b0;

        // dcache write with bmem_ready toggling 1,0,1,1,0,1
        @(negedge clk);
        n  = cyc;
        wd = mkLine(64'hA000_0000_0000_00A0, 64'hA111_0000_0000_00A1,
                    64'hA222_0000_0000_00A2, 64'hA333_0000_0000_00A3);
        for (int k = 0; k < 4; k++) expWr.push_back('{32'h0000_2000, wd[k*64 +: 64]});
        expResp.push_back('{1'b1, 1'b0, '0, n + 7});
        applyStimulus(0, 1, 0, 32'h0000_2000, 32'h0, wd);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bmem_ready = readyPat[k][0];
        end
        waitResp(1, "dwrite");
        d_write = 1'b0;

        // dcache and icache reads in the same cycle: dcache first
        @(negedge clk);
        n     = cyc;
        line  = mkLine(64'h5000_0000_0000_0005, 64'h5100_0000_0000_0015,
                       64'h5200_0000_0000_0025, 64'h5300_0000_0000_0035);
        line2 = mkLine(64'h6000_0000_0000_0006, 64'h6100_0000_0000_0016,
                       64'h6200_0000_0000_0026, 64'h6300_0000_0000_0036);
        memLineQ.push_back(line);
        memLineQ.push_back(line2);
        expRdAddr.push_back(32'h0000_5000);
        expRdAddr.push_back(32'h0000_6000);
        expResp.push_back('{1'b1, 1'b1, line, n + 6});
        expResp.push_back('{1'b0, 1'b1, line2, n + 13});
        applyStimulus(1, 0, 1, 32'h0000_5008, 32'h0000_6010, '0);
        waitResp(1, "dread_first");
        d_read = 1'b0;
        waitResp(0, "iread_second");
        i_read = 1'b0;

        // Reset asserted while beat 2 of a read is on the bus
        @(negedge clk);
        memLineQ.push_back(mkLine(64'h7, 64'h8, 64'h9, 64'hA));
        expRdAddr.push_back(32'h0000_3000);
        applyStimulus(0, 0, 1, 32'h0, 32'h0000_3000, '0);
        repeat (4) @(negedge clk);
        rst    = 1'b0;
        i_read = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        strayCount = 3;
        #1;
        checkOutput("abort_bmem_read", bmem_read, 1'b0);
        checkOutput("abort_i_resp", i_resp, 1'b0);
        repeat (5) begin
            @(negedge clk);
            #1;
            checkOutput("stray_bmem_read", bmem_read, 1'b0);
        end

        // Clean read after the aborted one
        @(negedge clk);
        n    = cyc;
        line = mkLine(64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0002,
                      64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0004);
        memLineQ.push_back(line);
        expRdAddr.push_back(32'h0000_4000);
        expResp.push_back('{1'b0, 1'b1, line, n + 6});
        applyStimulus(0, 0, 1, 32'h0, 32'h0000_401F, '0);
        waitResp(0, "iread_after_abort");
        i_read = 1'b0;

`ifdef ARB_PREFETCH_EN
        // Prefetch fills the buffer, further prefetches dropped until flush
        @(negedge clk);
        n    = cyc;
        line = mkLine(64'hBEEF_0000_0000_0010, 64'hBEEF_0000_0000_0020,
                      64'hBEEF_0000_0000_0030, 64'hBEEF_0000_0000_0040);
        memLineQ.push_back(line);
        expRdAddr.push_back(32'h0000_1020);
        prefetch_addr = 32'h0000_1020;
        prefetch      = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("pf_active_high", active_prefetch, 1'b1);
        for (int k = 0; k < 30 && !prefetch_rvalid; k++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("pf_rvalid", prefetch_rvalid, 1'b1);
        checkOutput("pf_load_cycle", cyc, n + 7);
        checkOutput("pf_active_low", active_prefetch, 1'b0);
        checkOutput("pf_raddr", prefetch_raddr, 32'h0000_1020);
        checkOutput("pf_rdata", prefetch_rdata, line);
        prefetch_addr = 32'h0000_1040;
        repeat (5) begin
            @(negedge clk);
            #1;
            checkOutput("pf_dropped_read", bmem_read, 1'b0);
            checkOutput("pf_held_rvalid", prefetch_rvalid, 1'b1);
        end
        @(negedge clk);
        prefetch       = 1'b0;
        flush_prefetch = 1'b1;
        #1;
        checkOutput("pf_rvalid_during_flush", prefetch_rvalid, 1'b1);
        @(negedge clk);
        flush_prefetch = 1'b0;
        #1;
        checkOutput("pf_rvalid_after_flush", prefetch_rvalid, 1'b0);
`else
        // Prefetch requests must be ignored entirely
        @(negedge clk);
        prefetch_addr = 32'h0000_7000;
        prefetch      = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #1;
            checkOutput("nopf_bmem_read", bmem_read, 1'b0);
            checkOutput("nopf_rvalid", prefetch_rvalid, 1'b0);
            checkOutput("nopf_active", active_prefetch, 1'b0);
        end
        @(negedge clk);
        prefetch = 1'b0;
`endif

        // Drain and confirm every queued expectation was consumed
        repeat (3) @(negedge clk);
        #1;
        checkOutput("sb_resp_left", expResp.size(), 0);
        checkOutput("sb_rdaddr_left", expRdAddr.size(), 0);
        checkOutput("sb_wrbeat_left", expWr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single burst memory port (bmem) among three requesters: data-cache fills/writebacks, instruction-cache demand fills, and the instruction-cache next-line prefetcher. Serializes 256-bit line writes into 64-bit beats and assembles 64-bit read beats into lines. Owns the one-entry prefetch line buffer that the instruction cache drains through `prefetch_rvalid`/`flush_prefetch`. Sits between both caches and the memory model, one transaction in flight at a time.

## Interface
- `LINE_SIZE`, 256, line width in bits
- `BEAT_SIZE`, 64, bmem data width; beats per line = LINE_SIZE/BEAT_SIZE (4)
- `clk` in 1 clock
- `rst` in 1 synchronous, active-low reset
- `d_addr` in 32, dcache line address; `d_read`, `d_write` in 1 each; `d_wdata` in LINE_SIZE
- `d_rdata` out LINE_SIZE; `d_resp` out 1
- `i_addr` in 32; `i_read` in 1; `i_rdata` out LINE_SIZE; `i_resp` out 1, demand fill
- `prefetch` in 1; `prefetch_addr` in 32, next-line request
- `prefetch_rdata` out LINE_SIZE; `prefetch_raddr` out 32; `prefetch_rvalid` out 1, buffered line
- `flush_prefetch` in 1, consumer releases the buffer
- `active_prefetch` out 1, prefetch granted and not yet buffered
- `bmem_addr` out 32; `bmem_read`, `bmem_write` out 1; `bmem_wdata` out BEAT_SIZE
- `bmem_ready` in 1; `bmem_raddr` in 32; `bmem_rdata` in BEAT_SIZE; `bmem_rvalid` in 1

## Operation
- Requests are level: requester holds read/write and address stable until its resp. `d_read` and `d_write` are never both high.
- All addresses forced line-aligned (bits [4:0] = 0) before use.
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.
- IDLE arbitration, fixed priority: dcache > icache demand > prefetch. Winner, address, op latched. Next state RD_REQ (reads) or WR_DATA (write).
- Prefetch eligible only when `prefetch_rvalid`=0, no prefetch in flight, and `prefetch_addr` differs from the latched demand address of the current cycle's `i_read`. Ineligible or lost prefetch requests are dropped, not queued.
- RD_REQ: `bmem_read`=1, `bmem_addr`=latched address until `bmem_ready`=1 sampled; then RD_DATA.
- RD_DATA: each `bmem_rvalid` beat k (0..3) written to line bits [64k+63:64k]; beat counter 2 bits, wraps 3->0. After beat 3 -> RESP.
- WR_DATA: `bmem_write`=1, `bmem_addr` latched, `bmem_wdata` = beat k of `d_wdata`; counter advances only on cycles with `bmem_ready`=1. After beat 3 accepted -> RESP.
- RESP (one cycle): demand winner gets its resp=1 with assembled line on rdata; prefetch winner loads buffer (`prefetch_rvalid` high next cycle, `prefetch_raddr` = latched address, `active_prefetch` drops). Next state IDLE.
- Buffer: `prefetch_rvalid` holds until `flush_prefetch`=1 sampled; cleared next cycle. Flush while empty is ignored.
- `bmem_rvalid` outside RD_DATA ignored.

## Timing
- Reset (rst=0 on clock edge): state IDLE, counter 0, buffer invalid; all resp, `bmem_read`, `bmem_write`, `prefetch_rvalid`, `active_prefetch` = 0; data/address outputs 0. Reset mid-burst abandons the transaction; no resp issued.
- Read latency from request in IDLE (ready immediate, beats back-to-back): grant cycle N, `bmem_read` N+1, beats N+2..N+5 earliest, resp N+6.
- Write with ready always high: grant N, beats N+1..N+4, resp N+5.
- Resp outputs are one-cycle pulses; rdata valid only while resp=1.
- Arbiter returns to IDLE the cycle after RESP; a still-held request is re-arbitrated there, so at most one grant per two cycles.
- `flush_prefetch` and buffer load in the same cycle cannot occur (load only when empty); flush wins only over an existing valid entry.

## Configuration
- `ARB_PREFETCH_EN` defined: prefetch port, buffer and `active_prefetch` as above.
- Undefined: `prefetch` ignored, `prefetch_rvalid`, `active_prefetch` tied 0, `prefetch_rdata`/`prefetch_raddr` tied 0, buffer not instantiated; arbitration is dcache > icache only.

## Test plan
- Reset then `i_read` at 0x0000_1004, memory returns beats 0x11..,0x22..,0x33..,0x44.. -> `bmem_addr`=0x0000_1000, `i_resp` one pulse, `i_rdata` = beat3:beat2:beat1:beat0.
- `d_write` to 0x0000_2000 with `bmem_ready` toggling 1,0,1,1,0,1 -> four beats in order, none duplicated, `d_resp` after fourth accepted beat.
- `d_read` and `i_read` asserted same cycle -> dcache served first, `i_resp` follows after second burst.
- Prefetch 0x0000_1020 -> `active_prefetch` high until buffer loads; `prefetch_rvalid`=1, `prefetch_raddr`=0x0000_1020 held; second prefetch dropped until `flush_prefetch`, then rvalid=0 next cycle.
- rst=0 during RD_DATA beat 2 -> no resp, state IDLE; stray `bmem_rvalid` beats ignored; next `i_read` completes correctly.
- Without `ARB_PREFETCH_EN`: `prefetch`=1 held for 20 cycles -> `bmem_read` never asserted, `prefetch_rvalid`=0.
